// File: rtl/conv3x3_mac_sequencer.sv
// Steps one 3x3 window through a shared two-cycle signed multiplier, one tap at a time,
// accumulating the nine products and presenting the full sum plus a clamped 8-bit pixel.
module conv3x3_mac_sequencer #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    k_wr,
  input  logic [3:0]              k_addr,
  input  logic [7:0]              k_data,
  input  logic                    pix_valid,
  input  logic [7:0]              pix_data,
  output logic                    pix_ready,
  output logic                    mul_req,
  output logic [7:0]              mul_x,
  output logic [7:0]              mul_y,
  input  logic                    mul_done,
  input  logic [15:0]             mul_z,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_acc,
  output logic [7:0]              res_pix,
  output logic                    busy,
  output logic                    k_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [7:0]       kern_q [0:8];
  logic signed [7:0]       kern_d [0:8];
  logic signed [7:0]       pbuf_q [0:8];
  logic signed [7:0]       pbuf_d [0:8];
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    k_err_q, k_err_d;
  logic                    pix_accept;
  logic signed [ACC_W-1:0] shifted;

  assign pix_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign pix_accept = pix_valid && pix_ready;

  always_comb begin
    state_d = state_q;
    kern_d  = kern_q;
    pbuf_d  = pbuf_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    k_err_d = 1'b0;

    // Kernel is only writable while idle; out-of-range taps are silently dropped.
    if (k_wr) begin
      if (state_q != S_IDLE) begin
        k_err_d = 1'b1;
      end else if (k_addr <= 4'd8) begin
        kern_d[k_addr] = k_data;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (pix_accept) begin
          pbuf_d[0] = pix_data;
          cnt_d     = 4'd1;
          acc_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pix_accept) begin
          pbuf_d[cnt_q] = pix_data;
          if (cnt_q == 4'd8) begin
            cnt_d   = '0;
            tap_d   = '0;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          acc_d = acc_q + ACC_W'($signed(mul_z));
          if (tap_q == 4'd8) begin
            tap_d   = '0;
            state_d = S_DONE;
          end else begin
            tap_d   = tap_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 9; i++) begin
        kern_q[i] <= '0;
        pbuf_q[i] <= '0;
      end
      cnt_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      k_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kern_q  <= kern_d;
      pbuf_q  <= pbuf_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      k_err_q <= k_err_d;
    end
  end

  // Operands stay driven across the wait so the multiplier may sample them late.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      mul_x = kern_q[tap_q];
      mul_y = pbuf_q[tap_q];
    end
  end

  assign mul_req   = (state_q == S_ISSUE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign k_err     = k_err_q;
  assign shifted   = acc_q >>> SHIFT;

  // Result ports read zero outside DONE so a stale sum is never presented.
  always_comb begin
    res_acc = '0;
    res_pix = '0;
    if (state_q == S_DONE) begin
      res_acc = acc_q;
      if (shifted[ACC_W-1]) begin
        res_pix = 8'd0;
      end else if (shifted > ACC_W'(255)) begin
        res_pix = 8'd255;
      end else begin
        res_pix = shifted[7:0];
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_sequencer.sv
// Directed and randomized windows against an arithmetic reference of the 3x3 dot product,
// with a two-cycle multiplier responder and a SHIFT=4 twin sharing the same inputs.
module tb_conv3x3_mac_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              k_wr;
  logic [3:0]        k_addr;
  logic [7:0]        k_data;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_ready;
  logic              mul_req;
  logic [7:0]        mul_x, mul_y;
  logic              mul_done = 1'b0;
  logic [15:0]       mul_z = '0;
  logic              res_valid;
  logic              res_ready;
  logic signed [19:0] res_acc;
  logic [7:0]        res_pix;
  logic              busy;
  logic              k_err;

  logic              s4_pix_ready, s4_mul_req, s4_res_valid, s4_busy, s4_k_err;
  logic [7:0]        s4_mul_x, s4_mul_y, s4_res_pix;
  logic signed [19:0] s4_res_acc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e_cyc = 0;
  int kmodel [9];
  int pix_vec [9];

  conv3x3_mac_sequencer #(.ACC_W(20), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .mul_req(mul_req), .mul_x(mul_x), .mul_y(mul_y), .mul_done(mul_done), .mul_z(mul_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc), .res_pix(res_pix),
    .busy(busy), .k_err(k_err)
  );

  conv3x3_mac_sequencer #(.ACC_W(20), .SHIFT(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(s4_pix_ready),
    .mul_req(s4_mul_req), .mul_x(s4_mul_x), .mul_y(s4_mul_y), .mul_done(mul_done), .mul_z(mul_z),
    .res_valid(s4_res_valid), .res_ready(res_ready), .res_acc(s4_res_acc), .res_pix(s4_res_pix),
    .busy(s4_busy), .k_err(s4_k_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle multiplier: operands captured with the request, product returned one cycle later.
  logic              req_d1 = 1'b0;
  logic signed [15:0] prod_d1 = '0;
  always @(posedge clk) begin
    req_d1   <= mul_req;
    prod_d1  <= $signed(mul_x) * $signed(mul_y);
    mul_done <= req_d1;
    mul_z    <= prod_d1;
  end

  function automatic int expSum();
    int s = 0;
    for (int i = 0; i < 9; i++) s += kmodel[i] * pix_vec[i];
    return s;
  endfunction

  function automatic int expPix(input int sum, input int sh);
    int v = sum >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic writeKernel(input int addr, input logic signed [7:0] data);
    @(negedge clk);
    k_wr   = 1'b1;
    k_addr = 4'(addr);
    k_data = data;
    @(negedge clk);
    k_wr = 1'b0;
    if (addr <= 8) kmodel[addr] = int'(data);
    checkOutput("k_err_idle", k_err, 0);
  endtask

  task automatic applyStimulus(input int gap_max);
    for (int i = 0; i < 9; i++) begin
      int gap;
      @(negedge clk);
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      while (gap > 0) begin
        pix_valid = 1'b0;
        @(negedge clk);
        gap--;
      end
      pix_valid = 1'b1;
      pix_data  = 8'(pix_vec[i]);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    e_cyc     = cyc;
  endtask

  task automatic awaitResult(input int hold, input string tag);
    int guard = 0;
    int es;
    while (res_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    es = expSum();
    checkOutput({tag, "_latency"}, cyc - e_cyc, 27);
    checkOutput({tag, "_acc"}, $signed(res_acc), es);
    checkOutput({tag, "_pix"}, res_pix, expPix(es, 0));
    checkOutput({tag, "_s4_acc"}, $signed(s4_res_acc), es);
    checkOutput({tag, "_s4_pix"}, s4_res_pix, expPix(es, 4));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, res_valid, 1);
      checkOutput({tag, "_hold_acc"}, $signed(res_acc), es);
      checkOutput({tag, "_hold_pix"}, res_pix, expPix(es, 0));
      checkOutput({tag, "_hold_ready"}, pix_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, res_valid, 0);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    rst_n     = 1'b0;
    k_wr      = 1'b0;
    k_addr    = '0;
    k_data    = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 9; i++) kmodel[i] = 0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pix_ready", pix_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_acc", $signed(res_acc), 0);
    checkOutput("rst_res_pix", res_pix, 0);
    checkOutput("rst_mul_req", mul_req, 0);
    checkOutput("rst_mul_x", mul_x, 0);
    checkOutput("rst_k_err", k_err, 0);
    rst_n = 1'b1;

    // All-ones kernel, pixels 1..9.
    for (int i = 0; i < 9; i++) writeKernel(i, 8'sd1);
    for (int i = 0; i < 9; i++) pix_vec[i] = i + 1;
    applyStimulus(0);
    awaitResult(0, "ones");

    // Single centre tap, most negative pixel.
    for (int i = 0; i < 9; i++) writeKernel(i, (i == 4) ? 8'sd127 : 8'sd0);
    for (int i = 0; i < 9; i++) pix_vec[i] = (i == 4) ? -128 : 5;
    applyStimulus(0);
    awaitResult(0, "centre");

    // Largest positive sum, must not wrap.
    for (int i = 0; i < 9; i++) writeKernel(i, 8'sd127);
    for (int i = 0; i < 9; i++) pix_vec[i] = 127;
    applyStimulus(0);
    awaitResult(0, "max");

    // Backpressure in DONE and gaps during LOAD.
    for (int i = 0; i < 9; i++) writeKernel(i, 8'sd1);
    for (int i = 0; i < 9; i++) pix_vec[i] = i + 1;
    applyStimulus(3);
    awaitResult(5, "hold");

    // Kernel write while waiting on the multiplier is rejected.
    applyStimulus(0);
    @(negedge clk);
    k_wr   = 1'b1;
    k_addr = 4'd3;
    k_data = 8'd9;
    @(negedge clk);
    k_wr   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      pulses += int'(k_err);
      @(negedge clk);
    end
    checkOutput("kerr_pulses", pulses, 1);
    awaitResult(0, "kerr");

    // Out-of-range address in IDLE: dropped, no error.
    writeKernel(12, 8'sd77);
    @(negedge clk);
    checkOutput("addr12_k_err", k_err, 0);
    for (int i = 0; i < 9; i++) pix_vec[i] = int'($signed(8'($urandom)));
    applyStimulus(1);
    awaitResult(0, "addr12");

    // Reset during the wait of tap 4 with a product still in flight.
    for (int i = 0; i < 9; i++) pix_vec[i] = i + 1;
    applyStimulus(0);
    repeat (14) @(negedge clk);
    checkOutput("pre_rst_busy", busy, 1);
    checkOutput("pre_rst_mul_y", mul_y, 5);
    checkOutput("pre_rst_mul_req", mul_req, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_mul_x", mul_x, 0);
    checkOutput("mid_rst_mul_y", mul_y, 0);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_res_acc", $signed(res_acc), 0);
    checkOutput("mid_rst_k_err", k_err, 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) kmodel[i] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_busy", busy, 0);
    end
    applyStimulus(0);
    awaitResult(0, "cleared");
    for (int i = 0; i < 9; i++) writeKernel(i, 8'sd1);
    applyStimulus(0);
    awaitResult(0, "reload");

    // Randomized windows.
    for (int w = 0; w < 15; w++) begin
      for (int i = 0; i < 9; i++) writeKernel(i, $signed(8'($urandom)));
      for (int i = 0; i < 9; i++) pix_vec[i] = int'($signed(8'($urandom)));
      applyStimulus(int'($urandom_range(0, 2)));
      awaitResult(int'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
